// File: rtl/nobl_sram_ctrl.sv
// Host-side controller for a 1M x 18 NoBL flow-through SRAM: byte-masked single writes, 1-4 beat reads.
// Optional statistics counters are enabled with `define NOBL_CTRL_STATS_EN.
module nobl_sram_ctrl #(
  parameter int unsigned AW = 20,
  parameter int unsigned DW = 18
`ifdef NOBL_CTRL_STATS_EN
  ,
  parameter int unsigned STATW = 16
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [1:0]    req_be,
  input  logic [DW-1:0] req_wdata,
  input  logic [1:0]    req_len,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_last,
  output logic          busy,
  output logic [AW-1:0] sram_a,
  output logic [1:0]    sram_bws,
  output logic          sram_we_b,
  output logic          sram_adv_lb,
  output logic          sram_ce1b,
  output logic          sram_ce2,
  output logic          sram_ce3b,
  output logic          sram_oeb,
  output logic          sram_cenb,
  output logic [DW-1:0] sram_dq_o,
  output logic          sram_dq_oe,
  input  logic [DW-1:0] sram_dq_i
`ifdef NOBL_CTRL_STATS_EN
  ,
  output logic [STATW-1:0] stat_rd,
  output logic [STATW-1:0] stat_wr
`endif
);

  typedef enum logic [0:0] {S_IDLE, S_RBURST} state_t;

  state_t        state, state_nxt;
  logic [1:0]    cnt_q, cnt_nxt;
  logic          accept, adv_beat, rd_beat, last_beat;

  // Pipeline: s1 = command on the pins, s2 = data phase on dq
  logic          s1_rd_q, s1_wr_q, s1_last_q;
  logic [DW-1:0] s1_wdata_q;
  logic          s2_rd_q, s2_last_q;

  assign sram_cenb = 1'b0;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt_q <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  // Next-state logic; cnt_q holds the beats still to issue
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    unique case (state)
      S_IDLE: begin
        if (accept && !req_we && req_len != 2'd0) begin
          state_nxt = S_RBURST;
          cnt_nxt   = req_len;
        end
      end
      S_RBURST: begin
        cnt_nxt = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode; a write right behind a read beat is held off for bus turnaround
  always_comb begin
    req_ready = 1'b0;
    adv_beat  = 1'b0;
    unique case (state)
      S_IDLE:   req_ready = !rst && !(s1_rd_q && req_we);
      S_RBURST: adv_beat  = 1'b1;
      default:  req_ready = 1'b0;
    endcase
    accept    = req_valid && req_ready;
    rd_beat   = (accept && !req_we) || adv_beat;
    last_beat = accept ? (req_len == 2'd0) : (cnt_q == 2'd1);
    busy      = !rst && (state == S_RBURST || s1_rd_q || s1_wr_q || s2_rd_q || sram_dq_oe);
  end

  // SRAM command pins
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_ce1b   <= 1'b1;
      sram_ce2    <= 1'b0;
      sram_ce3b   <= 1'b1;
      sram_we_b   <= 1'b1;
      sram_adv_lb <= 1'b0;
      sram_bws    <= 2'b11;
      sram_a      <= '0;
    end else if (accept) begin
      sram_ce1b   <= 1'b0;
      sram_ce2    <= 1'b1;
      sram_ce3b   <= 1'b0;
      sram_we_b   <= !req_we;
      sram_adv_lb <= 1'b0;
      sram_bws    <= req_we ? ~req_be : 2'b11;
      sram_a      <= req_addr;
    end else if (adv_beat) begin
      sram_we_b   <= 1'b1;
      sram_adv_lb <= 1'b1;
      sram_bws    <= 2'b11;
    end else begin
      sram_ce1b   <= 1'b1;
      sram_ce2    <= 1'b0;
      sram_ce3b   <= 1'b1;
      sram_we_b   <= 1'b1;
      sram_adv_lb <= 1'b0;
      sram_bws    <= 2'b11;
    end
  end

  // Data-phase pipeline and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_rd_q    <= 1'b0;
      s1_wr_q    <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_wdata_q <= '0;
      s2_rd_q    <= 1'b0;
      s2_last_q  <= 1'b0;
      sram_dq_oe <= 1'b0;
      sram_dq_o  <= '0;
      sram_oeb   <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_last   <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      s1_rd_q    <= rd_beat;
      s1_wr_q    <= accept && req_we;
      s1_last_q  <= last_beat;
      if (accept && req_we) s1_wdata_q <= req_wdata;
      s2_rd_q    <= s1_rd_q;
      s2_last_q  <= s1_last_q;
      sram_dq_oe <= s1_wr_q;
      if (s1_wr_q) sram_dq_o <= s1_wdata_q;
      sram_oeb   <= !s1_rd_q;
      rsp_valid  <= s2_rd_q;
      rsp_last   <= s2_rd_q && s2_last_q;
      if (s2_rd_q) rsp_rdata <= sram_dq_i;
    end
  end

`ifdef NOBL_CTRL_STATS_EN
  // Saturating beat counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd <= '0;
      stat_wr <= '0;
    end else begin
      if (s2_rd_q && stat_rd != '1) stat_rd <= stat_rd + STATW'(1);
      if (s1_wr_q && stat_wr != '1) stat_wr <= stat_wr + STATW'(1);
    end
  end
`else
  // Statistics counters compiled out.
`endif

endmodule

// File: tb/tb_nobl_sram_ctrl.sv
// Bench for nobl_sram_ctrl: pin-level SRAM model, host-level scoreboard, directed tables and random traffic.
module tb_nobl_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [19:0] req_addr;
  logic [1:0]  req_be, req_len;
  logic [17:0] req_wdata;
  logic        rsp_valid, rsp_last, busy;
  logic [17:0] rsp_rdata;
  logic [19:0] sram_a;
  logic [1:0]  sram_bws;
  logic        sram_we_b, sram_adv_lb, sram_ce1b, sram_ce2, sram_ce3b, sram_oeb, sram_cenb, sram_dq_oe;
  logic [17:0] sram_dq_o, sram_dq_i;
`ifdef NOBL_CTRL_STATS_EN
  logic [15:0] stat_rd, stat_wr;
`endif

  nobl_sram_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last), .busy(busy),
    .sram_a(sram_a), .sram_bws(sram_bws), .sram_we_b(sram_we_b), .sram_adv_lb(sram_adv_lb),
    .sram_ce1b(sram_ce1b), .sram_ce2(sram_ce2), .sram_ce3b(sram_ce3b), .sram_oeb(sram_oeb),
    .sram_cenb(sram_cenb), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i)
`ifdef NOBL_CTRL_STATS_EN
    , .stat_rd(stat_rd), .stat_wr(stat_wr)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Flow-through NoBL SRAM: command at edge N, write data at N+1, read data on dq during N..N+1
  logic [17:0] sram_mem [0:(1<<20)-1];
  logic        m_wr_pend = 1'b0, m_rd_v = 1'b0, m_burst_rd = 1'b0;
  logic [19:0] m_waddr = '0, m_addr = '0;
  logic [1:0]  m_wbws = 2'b11;
  logic [17:0] m_rd_data = '0;

  always @(posedge clk) begin : sram_model
    logic [17:0] merged;
    logic [19:0] na;
    logic        do_rd, do_wr;
    merged = sram_mem[m_waddr];
    if (!m_wbws[0]) merged[8:0]  = sram_dq_o[8:0];
    if (!m_wbws[1]) merged[17:9] = sram_dq_o[17:9];
    if (m_wr_pend && sram_dq_oe) sram_mem[m_waddr] <= merged;
    do_rd = 1'b0;
    do_wr = 1'b0;
    na    = m_addr;
    if (sram_adv_lb === 1'b0) begin
      if (!sram_ce1b && sram_ce2 && !sram_ce3b) begin
        na    = sram_a;
        do_wr = !sram_we_b;
        do_rd = sram_we_b;
      end
    end else if (sram_adv_lb === 1'b1 && m_burst_rd) begin
      na    = {m_addr[19:2], m_addr[1:0] + 2'd1};
      do_rd = 1'b1;
    end
    m_burst_rd <= do_rd;
    m_addr     <= na;
    m_wr_pend  <= do_wr;
    m_waddr    <= na;
    m_wbws     <= sram_bws;
    m_rd_v     <= do_rd;
    m_rd_data  <= (m_wr_pend && sram_dq_oe && na == m_waddr) ? merged : sram_mem[na];
  end

  assign sram_dq_i = (m_rd_v && !sram_oeb) ? m_rd_data : 18'h15A5A;

  // Host-level reference: memory image plus queue of expected read beats
  typedef struct {
    logic [17:0] d;
    logic        last;
  } exp_t;
  logic [17:0] ref_mem [0:(1<<20)-1];
  exp_t        exp_q[$];

  task automatic model_accept();
    if (req_we) begin
      logic [17:0] o;
      o = ref_mem[req_addr];
      if (req_be[0]) o[8:0]  = req_wdata[8:0];
      if (req_be[1]) o[17:9] = req_wdata[17:9];
      ref_mem[req_addr] = o;
    end else begin
      for (int i = 0; i <= int'(req_len); i++) begin
        logic [19:0] a;
        exp_t        e;
        a      = {req_addr[19:2], 2'(int'(req_addr[1:0]) + i)};
        e.d    = ref_mem[a];
        e.last = (i == int'(req_len));
        exp_q.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got rsp_valid with data %0h, required none", rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        check("rsp_data", 64'(rsp_rdata), 64'(e.d));
        check("rsp_last", 64'(rsp_last), 64'(e.last));
      end
    end
    if (rst === 1'b0) check("bus_contention", 64'(sram_dq_oe & ~sram_oeb), 64'(0));
    if (rst === 1'b0 && req_valid && req_ready) model_accept();
    if (rst === 1'b1) exp_q.delete();
  end

  task automatic send(input logic we, input logic [19:0] addr, input logic [1:0] be,
                      input logic [17:0] wd, input logic [1:0] len);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wd;
    req_len   = len;
    #1;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: req_ready stuck at 0, required 1");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  typedef struct {
    logic             we;
    logic [19:0]      addr;
    logic [1:0]       be;
    logic [17:0]      wdata;
    logic [1:0]       len;
    logic [3:0][17:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [19:0] addr, input logic [1:0] be,
                              input logic [17:0] wd, input logic [1:0] len,
                              input logic [17:0] e0, input logic [17:0] e1,
                              input logic [17:0] e2, input logic [17:0] e3);
    vec_t v;
    v.we = we; v.addr = addr; v.be = be; v.wdata = wd; v.len = len;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int k, c0, nrsp;
    for (int i = 0; i < (1 << 20); i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    tbl.push_back(mk(1, 20'h00010, 2'b11, 18'h2ABCD, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 20'h00010, 2'b00, 18'h0,     0, 18'h2ABCD, 0, 0, 0));
    tbl.push_back(mk(1, 20'h00020, 2'b01, 18'h3FFFF, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 20'h00020, 2'b00, 18'h0,     0, 18'h001FF, 0, 0, 0));
    tbl.push_back(mk(1, 20'h00040, 2'b11, 18'h11111, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 20'h00041, 2'b11, 18'h12222, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 20'h00042, 2'b11, 18'h23333, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 20'h00043, 2'b11, 18'h34444, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 20'h00042, 2'b00, 18'h0,     3, 18'h23333, 18'h34444, 18'h11111, 18'h12222));
    tbl.push_back(mk(1, 20'h00020, 2'b10, 18'h0AAAA, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 20'h00020, 2'b00, 18'h0,     0, 18'h0ABFF, 0, 0, 0));
    tbl.push_back(mk(0, 20'h00010, 2'b00, 18'h0,     1, 18'h2ABCD, 18'h0, 0, 0));

    // Reset state
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0; req_len = '0;
    repeat (3) step();
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rsp", 64'({rsp_valid, rsp_last, rsp_rdata}), 64'(0));
    check("rst_pins", 64'({sram_ce1b, sram_ce2, sram_ce3b, sram_we_b, sram_adv_lb, sram_bws,
                           sram_oeb, sram_cenb, sram_dq_oe}), 64'(10'b1011011100));
    check("rst_a_dq", 64'({sram_a, sram_dq_o}), 64'(0));
    req_valid = 1'b0;
    rst = 1'b0;
    step();
    check("idle_deselect", 64'({sram_ce1b, sram_we_b, sram_adv_lb, sram_bws}), 64'(5'b11011));

    // Write then read with pin-level timing
    send(1, 20'h00010, 2'b11, 18'h2ABCD, 0);
    check("wr_cmd", 64'({sram_ce1b, sram_ce2, sram_ce3b, sram_we_b, sram_adv_lb, sram_bws}), 64'(7'b0100000));
    check("wr_addr", 64'(sram_a), 64'(20'h00010));
    check("wr_no_oe_yet", 64'(sram_dq_oe), 64'(0));
    step();
    check("wr_dq", 64'({sram_dq_oe, sram_dq_o}), 64'({1'b1, 18'h2ABCD}));
    step();
    check("wr_dq_off", 64'(sram_dq_oe), 64'(0));
    send(0, 20'h00010, 2'b00, 18'h0, 0);
    check("rd_cmd", 64'({sram_ce1b, sram_ce2, sram_ce3b, sram_we_b, sram_adv_lb, sram_bws}), 64'(7'b0101011));
    step();
    check("rd_oeb", 64'({sram_oeb, rsp_valid}), 64'(0));
    step();
    check("rd_rsp", 64'({rsp_valid, rsp_last, rsp_rdata}), 64'({2'b11, 18'h2ABCD}));

    // Table of directed transactions
    foreach (tbl[t]) begin
      send(tbl[t].we, tbl[t].addr, tbl[t].be, tbl[t].wdata, tbl[t].len);
      if (!tbl[t].we) begin
        k = 0;
        for (int c = 0; c < 10 && k <= int'(tbl[t].len); c++) begin
          step();
          if (rsp_valid) begin
            check($sformatf("tbl%0d_data%0d", t, k), 64'(rsp_rdata), 64'(tbl[t].exp[k]));
            check($sformatf("tbl%0d_last%0d", t, k), 64'(rsp_last), 64'(k == int'(tbl[t].len)));
            k++;
          end
        end
        check($sformatf("tbl%0d_beats", t), 64'(k), 64'(int'(tbl[t].len) + 1));
      end else begin
        repeat (2) step();
      end
    end

    // Burst pins: load then three advance beats at a constant address
    send(0, 20'h00042, 2'b00, 18'h0, 3);
    check("burst_load", 64'({sram_adv_lb, sram_a}), 64'({1'b0, 20'h00042}));
    for (int b = 1; b <= 3; b++) begin
      check($sformatf("burst_hold_ready%0d", b), 64'({req_ready, busy}), 64'(2'b01));
      step();
      check($sformatf("burst_adv%0d", b), 64'({sram_ce1b, sram_ce2, sram_ce3b, sram_we_b, sram_adv_lb, sram_bws}),
            64'(7'b0101111));
      check($sformatf("burst_a%0d", b), 64'(sram_a), 64'(20'h00042));
    end
    step();
    check("burst_end", 64'({sram_ce1b, sram_adv_lb}), 64'(2'b10));
    repeat (3) step();

    // Read immediately followed by a write: one deselect cycle
    send(0, 20'h00001, 2'b00, 18'h0, 0);
    c0 = cyc;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 20'h00002; req_be = 2'b11; req_wdata = 18'h00155; req_len = 0;
    #1;
    check("turn_blocked", 64'(req_ready), 64'(0));
    step();
    check("turn_deselect", 64'({sram_ce1b, sram_we_b, sram_adv_lb, sram_bws}), 64'(5'b11011));
    check("turn_ready", 64'(req_ready), 64'(1));
    step();
    req_valid = 1'b0;
    check("turn_write", 64'({sram_we_b, sram_a}), 64'({1'b0, 20'h00002}));
    check("turn_gap", 64'(cyc - c0), 64'(2));
    repeat (3) step();

    // Back-to-back spacing for write-read, read-read and read-write
    send(1, 20'h00050, 2'b11, 18'h0ABC1, 0);
    c0 = cyc;
    send(0, 20'h00050, 2'b00, 18'h0, 0);
    check("b2b_wr_rd", 64'(cyc - c0), 64'(1));
    c0 = cyc;
    send(0, 20'h00051, 2'b00, 18'h0, 1);
    check("b2b_rd_rd", 64'(cyc - c0), 64'(1));
    c0 = cyc;
    send(1, 20'h00052, 2'b11, 18'h0ABC2, 0);
    check("b2b_rd_wr", 64'(cyc - c0), 64'(3));
    repeat (4) step();

    // Reset during beat 2 of a 4-beat burst
    send(0, 20'h00040, 2'b00, 18'h0, 3);
    step();
    step();
    rst = 1'b1;
    step();
    check("abort_pins", 64'({sram_ce1b, sram_dq_oe, sram_adv_lb}), 64'(3'b100));
    check("abort_host", 64'({rsp_valid, busy, req_ready}), 64'(0));
    rst = 1'b0;
    nrsp = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (rsp_valid) nrsp++;
    end
    check("abort_no_rsp", 64'(nrsp), 64'(0));
    send(0, 20'h00042, 2'b00, 18'h0, 0);
    step();
    step();
    check("post_abort_rd", 64'({rsp_valid, rsp_rdata}), 64'({1'b1, 18'h23333}));

`ifdef NOBL_CTRL_STATS_EN
    rst = 1'b1;
    step();
    check("stat_rst", 64'({stat_rd, stat_wr}), 64'(0));
    rst = 1'b0;
    for (int w = 0; w < 5; w++) send(1, 20'(20'h00060 + w), 2'b11, 18'(w), 0);
    send(0, 20'h00060, 2'b00, 18'h0, 2);
    repeat (6) step();
    check("stat_wr", 64'(stat_wr), 64'(5));
    check("stat_rd", 64'(stat_rd), 64'(3));
`endif

    // Random traffic against the reference model
    for (int r = 0; r < 300; r++) begin
      logic [19:0] ra;
      ra = ($urandom_range(0, 3) != 0) ? 20'($urandom_range(0, 63)) : 20'($urandom);
      send(1'($urandom_range(0, 1)), ra, 2'($urandom), 18'($urandom), 2'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end
    k = 0;
    while ((busy || exp_q.size() != 0) && k < 50) begin
      step();
      k++;
    end
    check("drain_queue", 64'(exp_q.size()), 64'(0));
    check("drain_busy", 64'(busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
